dense_layer_engine: RTL and testbench
=====================================

Name: dense_layer_engine

Overview:
- Parametrised successor to the fixed two-layer MNIST accelerator datapath; computes one fully connected layer.
- Streams N_IN signed inputs through N_OUT parallel MAC lanes. Each input is multiplied by that input's weight row, read from an external synchronous weight memory.
- Applies optional ReLU, then emits the N_OUT results sequentially on a valid/ready stream with index, last flag and running argmax.
- Layers are built by chaining instances: one instance's output stream feeds the next instance's input stream.

Parameters:
- DATA_W, 32, width of input samples and weights (signed two's complement).
- ACC_W, 32, accumulator and output width (signed).
- N_IN, 784, number of inputs per inference (>=1).
- N_OUT, 10, number of neurons/MAC lanes (>=1).
- RELU_EN, 1, 1 = clamp negative results to 0 on output; 0 = pass through.
- AW, $clog2(N_IN), weight address width (minimum 1).
- IW, $clog2(N_OUT), output index width (minimum 1).

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, asynchronous, active-low reset.
- start, input, 1, begin an inference; sampled only in IDLE or DONE.
- in_valid, input, 1, input sample valid.
- in_data, input, DATA_W, signed input sample.
- in_ready, output, 1, engine accepts a sample when in_valid&in_ready.
- w_addr, output, AW, weight row address, combinational = input count k.
- w_data, input, N_OUT*DATA_W, weight row; lane j at bits [j*DATA_W +: DATA_W]; valid one cycle after w_addr.
- out_valid, output, 1, result valid.
- out_ready, input, 1, downstream accepts.
- out_data, output, ACC_W, result of neuron out_idx.
- out_idx, output, IW, neuron index of out_data.
- out_last, output, 1, high with the beat for out_idx = N_OUT-1.
- argmax, output, IW, index of largest emitted result; valid when done.
- busy, output, 1, high in LOAD, DRAIN, EMIT.
- done, output, 1, one-cycle pulse on entering DONE.

Behaviour:
- Reset (reset=0, async):
  - state IDLE; all counters and accumulators 0.
  - in_ready=0, out_valid=0, out_last=0, done=0, busy=0.
  - out_data=0, out_idx=0, argmax=0, w_addr=0.
- States and transitions:
  - IDLE: start -> LOAD; clear accumulators, input counter k=0, argmax/max registers.
  - LOAD: in_ready=1. A transfer (in_valid&in_ready) registers in_data and increments k. The weight memory returns row k on w_data the next cycle. In that cycle lane j does acc_j += in_reg * w_j for every j.
  - LOAD -> DRAIN on acceptance of sample N_IN-1; in_ready drops in the same cycle as the transition.
  - DRAIN: one cycle completing the final MAC, then -> EMIT.
  - EMIT: out_valid=1. out_data = RELU_EN ? max(acc_i,0) : acc_i, with out_idx=i.
    - Values hold stable while out_ready=0.
    - On a handshake, i increments. The beat with i=N_OUT-1 has out_last=1; its handshake -> DONE.
  - DONE: done=1 for one cycle on entry; argmax is held. start -> LOAD, same clearing as from IDLE.
- Latency: with in_valid held high and out_ready=1, start to first out_valid is N_IN+2 cycles. The full output takes N_OUT further beats.
- Arithmetic:
  - Full signed product 2*DATA_W wide, truncated or sign-extended to ACC_W.
  - Accumulation wraps modulo 2^ACC_W; there is no saturation.
- Argmax:
  - Updated on each EMIT handshake using post-ReLU values.
  - A strictly greater value replaces the held maximum, so ties resolve to the lowest index.
  - Beat 0 always loads.
- Boundary conditions:
  - start in LOAD, DRAIN or EMIT is ignored.
  - in_valid outside LOAD is ignored (in_ready=0).
  - in_valid gaps stall LOAD with no MAC occurring; accumulators hold.
  - out_ready low indefinitely holds EMIT with no data change.
  - start and the last EMIT handshake in the same cycle: start is ignored; DONE is entered.
  - N_OUT=1: the single beat carries out_last=1 and argmax=0.
  - reset asserted mid-operation aborts immediately to IDLE. The partial inference is discarded and no done pulse occurs.

Test Plan:
- N_IN=4, N_OUT=2, RELU_EN=0; inputs 1,2,3,4; lane0 weights 1,1,1,1; lane1 weights -1,0,0,0 -> beats (0,10) then (1,-1); out_last on beat 1; argmax=0; done pulse once; first out_valid 6 cycles after start.
- Same data with RELU_EN=1 -> beat 1 = 0; lanes 0 and 1 with equal 0 values -> argmax resolves to the lower index.
- Backpressure: out_ready low for 5 cycles during beat 0 -> out_data/out_idx stable, no extra beats; then exactly N_OUT beats.
- in_valid toggling 1,0,1,0 during LOAD -> results identical to the unstalled run; w_addr advances only on transfers.
- Overflow, DATA_W=ACC_W=8: input 127, weight 127, N_IN=1 -> out_data = 8'h01 (16129 mod 256).
- reset low for 1 cycle mid-LOAD -> outputs at reset values immediately; a fresh start then gives correct results with no residue; start pulsed during EMIT is ignored.

Source files
------------

// File: rtl/dense_layer_engine.sv
// Fully connected layer: streams N_IN signed samples through N_OUT MAC lanes,
// then emits the (optionally ReLU'd) results one per beat with a running argmax.

module dle_mac_lane #(
   parameter int DATA_W = 32,
   parameter int ACC_W  = 32
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_clr,
   input  logic              i_en,
   input  logic [DATA_W-1:0] i_x,
   input  logic [DATA_W-1:0] i_w,
   output logic [ACC_W-1:0]  o_acc
);
   localparam int PW = (ACC_W > 2*DATA_W) ? ACC_W : 2*DATA_W;

   // Operands sign-extended to PW so the low ACC_W bits of the product are exact.
   logic signed [PW-1:0] w_x, w_w, w_prod;
   logic [ACC_W-1:0]     r_acc;

   assign w_x    = {{(PW-DATA_W){i_x[DATA_W-1]}}, i_x};
   assign w_w    = {{(PW-DATA_W){i_w[DATA_W-1]}}, i_w};
   assign w_prod = w_x * w_w;
   assign o_acc  = r_acc;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)  r_acc <= '0;
      else if (i_clr) r_acc <= '0;
      else if (i_en)  r_acc <= r_acc + ACC_W'(w_prod);
   end
endmodule

module dense_layer_engine #(
   parameter int DATA_W  = 32,
   parameter int ACC_W   = 32,
   parameter int N_IN    = 784,
   parameter int N_OUT   = 10,
   parameter int RELU_EN = 1,
   parameter int AW      = (N_IN > 1) ? $clog2(N_IN) : 1,
   parameter int IW      = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_start,
   input  logic                    i_in_valid,
   input  logic [DATA_W-1:0]       i_in_data,
   output logic                    o_in_ready,
   output logic [AW-1:0]           o_w_addr,
   input  logic [N_OUT*DATA_W-1:0] i_w_data,
   output logic                    o_out_valid,
   input  logic                    i_out_ready,
   output logic [ACC_W-1:0]        o_out_data,
   output logic [IW-1:0]           o_out_idx,
   output logic                    o_out_last,
   output logic [IW-1:0]           o_argmax,
   output logic                    o_busy,
   output logic                    o_done
);
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRAIN, S_EMIT, S_DONE} state_t;

   state_t                         r_state, w_state_nxt;
   logic [AW-1:0]                  r_k;
   logic [DATA_W-1:0]              r_in;
   logic                           r_mac;
   logic [IW-1:0]                  r_oidx;
   logic signed [ACC_W-1:0]        r_max;
   logic [IW-1:0]                  r_argmax;
   logic                           r_done;
   logic                           w_clear, w_in_fire, w_out_fire, w_k_last, w_o_last;
   logic [N_OUT-1:0][ACC_W-1:0]    w_acc;
   logic [ACC_W-1:0]               w_sel;
   logic signed [ACC_W-1:0]        w_val;

   // Weight row k arrives the cycle after its sample is registered; r_mac marks that cycle.
   for (genvar j = 0; j < N_OUT; j++) begin : g_lane
      dle_mac_lane #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_lane (
         .i_clk   (i_clk),
         .i_rst_n (i_rst_n),
         .i_clr   (w_clear),
         .i_en    (r_mac),
         .i_x     (r_in),
         .i_w     (i_w_data[j*DATA_W +: DATA_W]),
         .o_acc   (w_acc[j])
      );
   end

   if (N_OUT == 1) begin : g_sel1
      assign w_sel = w_acc[0];
   end else begin : g_seln
      assign w_sel = w_acc[r_oidx];
   end

   assign w_val      = ((RELU_EN != 0) && w_sel[ACC_W-1]) ? '0 : $signed(w_sel);
   assign w_k_last   = (r_k == AW'(N_IN-1));
   assign w_o_last   = (r_oidx == IW'(N_OUT-1));
   assign w_in_fire  = i_in_valid & o_in_ready;
   assign w_out_fire = o_out_valid & i_out_ready;

   assign o_w_addr   = r_k;
   assign o_out_data = o_out_valid ? w_val : '0;
   assign o_out_idx  = r_oidx;
   assign o_out_last = o_out_valid & w_o_last;
   assign o_argmax   = r_argmax;
   assign o_done     = r_done;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_clear     = 1'b0;
      o_in_ready  = 1'b0;
      o_out_valid = 1'b0;
      o_busy      = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (i_start) begin
               w_state_nxt = S_LOAD;
               w_clear     = 1'b1;
            end
         end
         S_LOAD: begin
            o_in_ready = 1'b1;
            o_busy     = 1'b1;
            if (i_in_valid && w_k_last) w_state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            o_busy      = 1'b1;
            w_state_nxt = S_EMIT;
         end
         S_EMIT: begin
            o_out_valid = 1'b1;
            o_busy      = 1'b1;
            if (i_out_ready && w_o_last) w_state_nxt = S_DONE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_k      <= '0;
         r_in     <= '0;
         r_mac    <= 1'b0;
         r_oidx   <= '0;
         r_max    <= '0;
         r_argmax <= '0;
         r_done   <= 1'b0;
      end else begin
         r_mac  <= w_in_fire;
         r_done <= w_out_fire & w_o_last;
         if (w_clear) begin
            r_k      <= '0;
            r_oidx   <= '0;
            r_max    <= '0;
            r_argmax <= '0;
         end else begin
            if (w_in_fire) begin
               r_in <= i_in_data;
               r_k  <= r_k + 1'b1;
            end
            if (w_out_fire) begin
               r_oidx <= w_o_last ? '0 : r_oidx + 1'b1;
               // Strictly greater keeps the lowest index on ties; beat 0 always seeds.
               if (r_oidx == '0 || w_val > r_max) begin
                  r_max    <= w_val;
                  r_argmax <= r_oidx;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_dense_layer_engine.sv
// Bench for dense_layer_engine: table vectors, random vectors against an arithmetic
// model, and hand sequences for reset abort and a 1-input/1-output 8-bit instance.

module tb_dense_layer_engine;
   localparam int DW = 16, AWD = 32, NI = 4, NO = 2;

   typedef logic [NI-1:0][DW-1:0]         xv_t;
   typedef logic [NI-1:0][NO-1:0][DW-1:0] wv_t;
   typedef logic [NO-1:0][AWD-1:0]        ov_t;
   typedef struct packed {
      xv_t        x;
      wv_t        w;
      ov_t        e_lin;
      ov_t        e_relu;
      logic       am_lin;
      logic       am_relu;
      logic [1:0] gaps;
      logic [2:0] hold;
      logic       spam;
   } vec_t;

   logic clk = 1'b0, rst_n = 1'b1;
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc++;

   // Shared stimulus for the linear (a) and ReLU (b) instances.
   logic          start, in_valid, out_ready;
   logic [DW-1:0] in_data;
   wv_t           mem;
   logic          in_ready_a, in_ready_b, out_valid_a, out_valid_b, out_last_a, out_last_b;
   logic          busy_a, busy_b, done_a, done_b;
   logic [1:0]    w_addr_a, w_addr_b;
   logic [NO*DW-1:0] wd_a, wd_b;
   logic [AWD-1:0] out_data_a, out_data_b;
   logic [0:0]    out_idx_a, out_idx_b, argmax_a, argmax_b;

   logic          start_c, in_valid_c, out_ready_c, in_ready_c, out_valid_c, out_last_c, busy_c, done_c;
   logic [7:0]    in_data_c, memc, wd_c, out_data_c;
   logic [0:0]    w_addr_c, out_idx_c, argmax_c;

   always @(posedge clk) begin
      wd_a <= mem[w_addr_a];
      wd_b <= mem[w_addr_b];
      wd_c <= memc;
   end

   dense_layer_engine #(.DATA_W(DW), .ACC_W(AWD), .N_IN(NI), .N_OUT(NO), .RELU_EN(0)) u_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_in_valid(in_valid), .i_in_data(in_data),
      .o_in_ready(in_ready_a), .o_w_addr(w_addr_a), .i_w_data(wd_a), .o_out_valid(out_valid_a),
      .i_out_ready(out_ready), .o_out_data(out_data_a), .o_out_idx(out_idx_a), .o_out_last(out_last_a),
      .o_argmax(argmax_a), .o_busy(busy_a), .o_done(done_a));

   dense_layer_engine #(.DATA_W(DW), .ACC_W(AWD), .N_IN(NI), .N_OUT(NO), .RELU_EN(1)) u_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_in_valid(in_valid), .i_in_data(in_data),
      .o_in_ready(in_ready_b), .o_w_addr(w_addr_b), .i_w_data(wd_b), .o_out_valid(out_valid_b),
      .i_out_ready(out_ready), .o_out_data(out_data_b), .o_out_idx(out_idx_b), .o_out_last(out_last_b),
      .o_argmax(argmax_b), .o_busy(busy_b), .o_done(done_b));

   dense_layer_engine #(.DATA_W(8), .ACC_W(8), .N_IN(1), .N_OUT(1), .RELU_EN(0)) u_c (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start_c), .i_in_valid(in_valid_c), .i_in_data(in_data_c),
      .o_in_ready(in_ready_c), .o_w_addr(w_addr_c), .i_w_data(wd_c), .o_out_valid(out_valid_c),
      .i_out_ready(out_ready_c), .o_out_data(out_data_c), .o_out_idx(out_idx_c), .o_out_last(out_last_c),
      .o_argmax(argmax_c), .o_busy(busy_c), .o_done(done_c));

   int dcnt_a = 0, dcnt_b = 0, dcnt_c = 0;
   always @(negedge clk) begin
      if (done_a === 1'b1) dcnt_a++;
      if (done_b === 1'b1) dcnt_b++;
      if (done_c === 1'b1) dcnt_c++;
   end

   int n_vec = 0, n_err = 0;
   task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   // Reference: dot products in 64-bit integers, wrapped to 32 bits, then optional clamp.
   function automatic ov_t model(input xv_t x, input wv_t w, input bit relu);
      ov_t r;
      for (int j = 0; j < NO; j++) begin
         longint s = 0;
         for (int k = 0; k < NI; k++) s += longint'($signed(x[k])) * longint'($signed(w[k][j]));
         r[j] = s[31:0];
         if (relu && r[j][31]) r[j] = '0;
      end
      return r;
   endfunction

   function automatic int amax(input ov_t v);
      int best = 0;
      for (int j = 1; j < NO; j++) if ($signed(v[j]) > $signed(v[best])) best = j;
      return best;
   endfunction

   function automatic xv_t xv(input int a, input int b, input int c, input int d);
      xv_t r;
      r[0] = DW'(a); r[1] = DW'(b); r[2] = DW'(c); r[3] = DW'(d);
      return r;
   endfunction

   function automatic wv_t wv(input int a0, input int b0, input int c0, input int d0,
                              input int a1, input int b1, input int c1, input int d1);
      wv_t r;
      r[0][0] = DW'(a0); r[1][0] = DW'(b0); r[2][0] = DW'(c0); r[3][0] = DW'(d0);
      r[0][1] = DW'(a1); r[1][1] = DW'(b1); r[2][1] = DW'(c1); r[3][1] = DW'(d1);
      return r;
   endfunction

   function automatic ov_t ov(input int a, input int b);
      ov_t r;
      r[0] = AWD'(a); r[1] = AWD'(b);
      return r;
   endfunction

   task automatic chk_reset(input string tag);
      chk({tag, " in_ready"}, in_ready_a, 0);
      chk({tag, " out_valid"}, out_valid_a, 0);
      chk({tag, " out_last"}, out_last_a, 0);
      chk({tag, " done"}, done_a, 0);
      chk({tag, " busy"}, busy_a, 0);
      chk({tag, " out_data"}, out_data_a, 0);
      chk({tag, " out_idx"}, out_idx_a, 0);
      chk({tag, " argmax"}, argmax_a, 0);
      chk({tag, " w_addr"}, w_addr_a, 0);
      chk({tag, " b busy"}, busy_b, 0);
      chk({tag, " c busy"}, busy_c, 0);
      chk({tag, " c w_addr"}, w_addr_c, 0);
      chk({tag, " c out_data"}, out_data_c, 0);
   endtask

   // Entered and left on a negedge.
   task automatic run_ab(input vec_t v, input string tag);
      int k, beat, guard, lat, held, t0, da0, db0;
      logic vl, fire;
      mem = v.w; da0 = dcnt_a; db0 = dcnt_b;
      start = 1'b1; t0 = cyc;
      @(negedge clk);
      start = 1'b0;
      k = 0; guard = 0; vl = 1'b0;
      while (k < NI && guard < 100) begin
         chk({tag, " w_addr"}, w_addr_a, k);
         chk({tag, " in_ready a"}, in_ready_a, 1);
         chk({tag, " in_ready b"}, in_ready_b, 1);
         case (v.gaps)
            2'd0:    vl = 1'b1;
            2'd1:    vl = ~vl;
            default: vl = 1'($urandom_range(0, 1));
         endcase
         in_valid = vl; in_data = v.x[k];
         fire = vl && in_ready_a;
         @(negedge clk);
         if (fire) k++;
         guard++;
      end
      in_valid = 1'b0;
      chk({tag, " load count"}, k, NI);
      chk({tag, " in_ready drop"}, in_ready_a, 0);
      beat = 0; guard = 0; lat = -1; held = 0;
      while (beat < NO && guard < 100) begin
         if (v.spam) start = 1'b1;
         if (out_valid_a && lat < 0) lat = cyc - t0;
         out_ready = (beat == 0 && held < int'(v.hold)) ? 1'b0 : 1'b1;
         if (out_valid_a) begin
            if (!out_ready) begin
               held++;
               chk({tag, " hold data a"}, $signed(out_data_a), $signed(v.e_lin[0]));
               chk({tag, " hold data b"}, $signed(out_data_b), $signed(v.e_relu[0]));
               chk({tag, " hold idx"}, out_idx_a, 0);
            end else begin
               chk({tag, " data a"}, $signed(out_data_a), $signed(v.e_lin[beat]));
               chk({tag, " data b"}, $signed(out_data_b), $signed(v.e_relu[beat]));
               chk({tag, " idx a"}, out_idx_a, beat);
               chk({tag, " idx b"}, out_idx_b, beat);
               chk({tag, " last a"}, out_last_a, (beat == NO-1));
               chk({tag, " last b"}, out_last_b, (beat == NO-1));
               beat++;
            end
         end
         @(negedge clk);
         guard++;
      end
      start = 1'b0; out_ready = 1'b1;
      chk({tag, " beats"}, beat, NO);
      if (v.gaps == 2'd0) chk({tag, " latency"}, lat, NI + 2 + int'(v.hold) * 0);
      chk({tag, " extra beat"}, out_valid_a, 0);
      chk({tag, " busy a"}, busy_a, 0);
      chk({tag, " busy b"}, busy_b, 0);
      chk({tag, " argmax a"}, argmax_a, v.am_lin);
      chk({tag, " argmax b"}, argmax_b, v.am_relu);
      repeat (2) @(negedge clk);
      chk({tag, " done pulses a"}, dcnt_a - da0, 1);
      chk({tag, " done pulses b"}, dcnt_b - db0, 1);
   endtask

   task automatic run_c(input int x, input int w, input int e, input string tag);
      int t0, dc0;
      memc = 8'(w); dc0 = dcnt_c;
      start_c = 1'b1; t0 = cyc;
      @(negedge clk);
      start_c = 1'b0;
      chk({tag, " in_ready"}, in_ready_c, 1);
      in_valid_c = 1'b1; in_data_c = 8'(x);
      @(negedge clk);
      in_valid_c = 1'b0;
      chk({tag, " drain"}, out_valid_c, 0);
      @(negedge clk);
      chk({tag, " valid"}, out_valid_c, 1);
      chk({tag, " latency"}, cyc - t0, 3);
      chk({tag, " data"}, $signed(out_data_c), e);
      chk({tag, " idx"}, out_idx_c, 0);
      chk({tag, " last"}, out_last_c, 1);
      @(negedge clk);
      chk({tag, " after valid"}, out_valid_c, 0);
      chk({tag, " busy"}, busy_c, 0);
      chk({tag, " argmax"}, argmax_c, 0);
      repeat (2) @(negedge clk);
      chk({tag, " done pulses"}, dcnt_c - dc0, 1);
   endtask

   vec_t tbl [7];

   initial begin
      int da0;
      vec_t rv;
      start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; mem = '0;
      start_c = 1'b0; in_valid_c = 1'b0; in_data_c = '0; out_ready_c = 1'b1; memc = '0;

      tbl[0] = '{xv(1,2,3,4), wv(1,1,1,1, -1,0,0,0), ov(10,-1), ov(10,0), 1'b0, 1'b0, 2'd0, 3'd0, 1'b0};
      tbl[1] = '{xv(1,2,3,4), wv(1,1,1,1, -1,0,0,0), ov(10,-1), ov(10,0), 1'b0, 1'b0, 2'd1, 3'd0, 1'b0};
      tbl[2] = '{xv(1,2,3,4), wv(1,1,1,1, -1,0,0,0), ov(10,-1), ov(10,0), 1'b0, 1'b0, 2'd0, 3'd5, 1'b1};
      tbl[3] = '{xv(1,2,3,4), wv(-1,-1,-1,-1, -1,0,0,0), ov(-10,-1), ov(0,0), 1'b1, 1'b0, 2'd0, 3'd0, 1'b0};
      tbl[4] = '{xv(5,0,0,0), wv(1,7,7,7, 1,-3,2,9), ov(5,5), ov(5,5), 1'b0, 1'b0, 2'd0, 3'd1, 1'b0};
      tbl[5] = '{xv(-2,3,100,-1), wv(3,3,3,3, 0,0,4,-5), ov(300,405), ov(300,405), 1'b1, 1'b1, 2'd1, 3'd0, 1'b0};
      tbl[6] = '{xv(30000,30000,30000,30000), wv(30000,30000,30000,30000, -30000,-30000,-30000,-30000),
                 ov(-694967296,694967296), ov(0,694967296), 1'b1, 1'b1, 2'd2, 3'd2, 1'b1};

      #2 rst_n = 1'b0;
      #1 chk_reset("reset");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 7; i++) run_ab(tbl[i], $sformatf("tbl%0d", i));

      // Abort mid-LOAD, then a fresh inference must show no residue.
      da0 = dcnt_a;
      mem = tbl[6].w;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0; in_valid = 1'b1; in_data = 16'sd30000;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1 chk_reset("abort");
      @(negedge clk);
      rst_n = 1'b1; in_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("abort no done", dcnt_a - da0, 0);
      chk("abort idle busy", busy_a, 0);
      run_ab(tbl[5], "post abort");

      for (int i = 0; i < 20; i++) begin
         for (int k = 0; k < NI; k++) begin
            rv.x[k] = (i % 2 == 0) ? DW'($urandom) : DW'($urandom_range(0, 40) - 20);
            for (int j = 0; j < NO; j++)
               rv.w[k][j] = (i % 3 == 0) ? DW'($urandom) : DW'($urandom_range(0, 40) - 20);
         end
         rv.e_lin   = model(rv.x, rv.w, 1'b0);
         rv.e_relu  = model(rv.x, rv.w, 1'b1);
         rv.am_lin  = 1'(amax(rv.e_lin));
         rv.am_relu = 1'(amax(rv.e_relu));
         rv.gaps    = 2'($urandom_range(0, 2));
         rv.hold    = 3'($urandom_range(0, 3));
         rv.spam    = 1'($urandom_range(0, 1));
         run_ab(rv, $sformatf("rnd%0d", i));
      end

      run_c(127, 127, 1, "c 127x127");
      run_c(-128, -128, 0, "c -128x-128");
      run_c(-3, 5, -15, "c -3x5");
      run_c(100, -2, 56, "c 100x-2");
      run_c(-128, 127, -128, "c -128x127");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end
endmodule
